io_bridge_mux: RTL and testbench

Parametrised, handshaked successor to the CPU-to-peripheral bridge. It decodes each CPU access to either the DRAM channel or one of `NUM_SLV` memory-mapped peripheral slots, registers the request, and waits for the target's ready. It returns registered read data with a one-cycle acknowledge. Unmapped, illegal or timed-out accesses produce a bus-error response instead of a silent `FFFF_FFFF`. It sits between the pipeline's MEM stage and the DRAM/peripheral blocks, letting slow peripherals insert wait states.

---
 rtl/io_bridge_mux_if.sv | 47 ++++
 rtl/io_bridge_mux.sv | 154 +++++++++++++++
 tb/tb_io_bridge_mux.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_bridge_mux_if.sv
// CPU, DRAM and peripheral-slot signals of the bridge in one bundle.
// The bridge uses the slave view; the CPU and target models use the master view.
interface io_bridge_mux_if #(
  parameter int unsigned NUM_SLV = 6,
  parameter int unsigned DATA_W  = 32
);
  logic                        req_from_cpu;
  logic                        we_from_cpu;
  logic [31:0]                 addr_from_cpu;
  logic [DATA_W-1:0]           wdata_from_cpu;
  logic [DATA_W-1:0]           rdata_to_cpu;
  logic                        ack_to_cpu;
  logic                        err_to_cpu;
  logic                        busy_to_cpu;

  logic                        req_to_dram;
  logic                        we_to_dram;
  logic [31:0]                 addr_to_dram;
  logic [DATA_W-1:0]           wdata_to_dram;
  logic [DATA_W-1:0]           rdata_from_dram;
  logic                        rdy_from_dram;

  logic [NUM_SLV-1:0]          sel_to_slv;
  logic                        we_to_slv;
  logic [31:0]                 addr_to_slv;
  logic [DATA_W-1:0]           wdata_to_slv;
  logic [NUM_SLV*DATA_W-1:0]   rdata_from_slv;
  logic [NUM_SLV-1:0]          rdy_from_slv;

  modport slave (
    input  req_from_cpu, we_from_cpu, addr_from_cpu, wdata_from_cpu,
    output rdata_to_cpu, ack_to_cpu, err_to_cpu, busy_to_cpu,
    output req_to_dram, we_to_dram, addr_to_dram, wdata_to_dram,
    input  rdata_from_dram, rdy_from_dram,
    output sel_to_slv, we_to_slv, addr_to_slv, wdata_to_slv,
    input  rdata_from_slv, rdy_from_slv
  );

  modport master (
    output req_from_cpu, we_from_cpu, addr_from_cpu, wdata_from_cpu,
    input  rdata_to_cpu, ack_to_cpu, err_to_cpu, busy_to_cpu,
    input  req_to_dram, we_to_dram, addr_to_dram, wdata_to_dram,
    output rdata_from_dram, rdy_from_dram,
    input  sel_to_slv, we_to_slv, addr_to_slv, wdata_to_slv,
    output rdata_from_slv, rdy_from_slv
  );
endinterface

// File: rtl/io_bridge_mux.sv
// CPU-to-DRAM/peripheral bridge: decodes one access at a time, waits for the
// target's ready (or a timeout) and returns registered data with a one-cycle ack.
module io_bridge_mux #(
  parameter int unsigned        NUM_SLV   = 6,
  parameter int unsigned        DATA_W    = 32,
  parameter logic [19:0]        PERI_PAGE = 20'hFFFFF,
  parameter logic [11:0]        SLV_BASE  = 12'h000,
  parameter logic [NUM_SLV-1:0] RD_MASK   = '1,
  parameter logic [NUM_SLV-1:0] WR_MASK   = '1,
  parameter int unsigned        TIMEOUT   = 15
) (
  input  logic           clk_from_cpu,
  input  logic           rst_from_cpu,
  io_bridge_mux_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               dram_q, dram_d;
  logic [NUM_SLV-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_SLV-1:0] hit;
  logic               peri;
  logic               tgt_rdy;
  logic [DATA_W-1:0]  slv_rdata;
  logic [DATA_W-1:0]  tgt_rdata;

  // Address decode of the incoming request and muxing of the active target.
  always_comb begin
    hit  = '0;
    peri = (bus.addr_from_cpu[31:12] == PERI_PAGE);
    for (int k = 0; k < NUM_SLV; k++) begin
      hit[k] = (bus.addr_from_cpu[11:0] == SLV_BASE + 12'(4 * k));
    end
    slv_rdata = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (sel_q[k]) slv_rdata = bus.rdata_from_slv[k*DATA_W +: DATA_W];
    end
    // Only the selected target's ready counts; others are masked off by sel_q.
    tgt_rdy   = dram_q ? bus.rdy_from_dram : |(sel_q & bus.rdy_from_slv);
    tgt_rdata = dram_q ? bus.rdata_from_dram : slv_rdata;
  end

  // NOTE: every signal gets a hold-value default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    dram_d  = dram_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_from_cpu) begin
          addr_d  = bus.addr_from_cpu;
          we_d    = bus.we_from_cpu;
          wdata_d = bus.wdata_from_cpu;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (!peri) begin
            dram_d  = 1'b1;
            state_d = ACCESS;
          end else if (hit == '0 || (bus.we_from_cpu && (hit & WR_MASK) == '0)) begin
            err_d   = 1'b1;
            rdata_d = '1;
            state_d = RESP;
          end else if (!bus.we_from_cpu && (hit & RD_MASK) == '0) begin
            // Read-protected slot answers like the legacy bridge: all ones, no error.
            rdata_d = '1;
            state_d = RESP;
          end else begin
            sel_d   = hit;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (tgt_rdy) begin
          rdata_d = we_q ? '0 : tgt_rdata;
          err_d   = 1'b0;
          dram_d  = 1'b0;
          sel_d   = '0;
          state_d = RESP;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          rdata_d = '1;
          err_d   = 1'b1;
          dram_d  = 1'b0;
          sel_d   = '0;
          state_d = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk_from_cpu) begin
    if (rst_from_cpu) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      dram_q  <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      dram_q  <= dram_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.req_to_dram   = dram_q;
    bus.we_to_dram    = dram_q & we_q;
    bus.addr_to_dram  = addr_q;
    bus.wdata_to_dram = wdata_q;
    bus.sel_to_slv    = sel_q;
    bus.we_to_slv     = (|sel_q) & we_q;
    bus.addr_to_slv   = addr_q;
    bus.wdata_to_slv  = wdata_q;
    bus.ack_to_cpu    = (state_q == RESP);
    bus.err_to_cpu    = (state_q == RESP) & err_q;
    bus.rdata_to_cpu  = rdata_q;
    bus.busy_to_cpu   = (state_q != IDLE);
  end

endmodule

// File: tb/tb_io_bridge_mux.sv
// Directed bench for io_bridge_mux: a driver queues expected responses, a
// monitor checks each ack against the queue, a responder models the targets.
module tb_io_bridge_mux;

  localparam int NS = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_bridge_mux_if #(.NUM_SLV(NS), .DATA_W(DW)) bus ();

  io_bridge_mux #(
    .NUM_SLV(NS), .DATA_W(DW), .PERI_PAGE(20'hFFFFF), .SLV_BASE(12'h000),
    .RD_MASK(6'b011111), .WR_MASK(6'b101111), .TIMEOUT(15)
  ) dut (
    .clk_from_cpu(clk),
    .rst_from_cpu(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          edge_n;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Target model state (responder is the only writer of the counters).
  int          wait_n = 0;
  logic [NS-1:0] spur = '0;
  int          sel_cnt = 0;
  int          sel_run = 0;
  int          dram_run = 0;
  logic [NS-1:0] sel_or = '0;
  int          stable_bad = 0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.ack_to_cpu) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ack_rdata", bus.rdata_to_cpu, e.rdata);
        check("ack_err", bus.err_to_cpu, e.err);
        check("ack_edge", cyc, e.edge_n);
      end
    end
  end

  // Responder: raises the selected target's ready after wait_n select cycles.
  always @(negedge clk) begin
    logic ready_now;
    if (rst || !bus.busy_to_cpu) begin
      sel_run  = 0;
      dram_run = 0;
      sel_or   = '0;
    end
    if (!rst && (bus.req_to_dram || (|bus.sel_to_slv))) begin
      sel_run++;
      sel_or = sel_or | bus.sel_to_slv;
      if (bus.req_to_dram) begin
        dram_run++;
        if (bus.we_to_dram !== exp_we || bus.we_to_slv !== 1'b0 || (|bus.sel_to_slv) ||
            bus.addr_to_dram !== exp_addr || bus.wdata_to_dram !== exp_wdata)
          stable_bad++;
      end else begin
        if (bus.we_to_slv !== exp_we || bus.we_to_dram !== 1'b0 || !$onehot(bus.sel_to_slv) ||
            bus.addr_to_slv !== exp_addr || bus.wdata_to_slv !== exp_wdata)
          stable_bad++;
      end
      ready_now = (wait_n >= 0) && (sel_cnt == wait_n);
      bus.rdy_from_dram = bus.req_to_dram & ready_now;
      bus.rdy_from_slv  = (ready_now ? bus.sel_to_slv : '0) | spur;
      sel_cnt++;
    end else begin
      if (bus.we_to_dram || bus.we_to_slv) stable_bad++;
      sel_cnt = 0;
      bus.rdy_from_dram = 1'b0;
      bus.rdy_from_slv  = spur;
    end
  end

  task automatic wait_ack(input string name);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.ack_to_cpu) return;
    end
    check({name, "_ack_timeout"}, 0, 1);
  endtask

  task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int wn, output int e);
    @(negedge clk);
    wait_n = wn;
    exp_we = we;
    exp_addr = addr;
    exp_wdata = wdata;
    bus.req_from_cpu   = 1'b1;
    bus.we_from_cpu    = we;
    bus.addr_from_cpu  = addr;
    bus.wdata_from_cpu = wdata;
    e = cyc + 1;
  endtask

  task automatic run_access(input string name, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int wn, input logic exp_err,
                            input logic [31:0] exp_rd, input int lat, input int exp_cycles,
                            input logic [NS-1:0] exp_sel, input int exp_dram);
    int e;
    start_req(we, addr, wdata, wn, e);
    sb_q.push_back('{exp_err, exp_rd, e + lat - 1});
    wait_ack(name);
    bus.req_from_cpu = 1'b0;
    check({name, "_sel_cycles"}, sel_run, exp_cycles);
    check({name, "_sel_slots"}, sel_or, exp_sel);
    check({name, "_dram_cycles"}, dram_run, exp_dram);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    bus.req_from_cpu    = 1'b0;
    bus.we_from_cpu     = 1'b0;
    bus.addr_from_cpu   = '0;
    bus.wdata_from_cpu  = '0;
    bus.rdata_from_dram = 32'hDEADBEEF;
    bus.rdy_from_dram   = 1'b0;
    bus.rdy_from_slv    = '0;
    for (int k = 0; k < NS; k++) bus.rdata_from_slv[k*DW +: DW] = 32'h5100_0000 | k;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", bus.ack_to_cpu, 0);
    check("rst_err", bus.err_to_cpu, 0);
    check("rst_busy", bus.busy_to_cpu, 0);
    check("rst_dram", {bus.req_to_dram, bus.we_to_dram}, 0);
    check("rst_slv", {bus.sel_to_slv, bus.we_to_slv}, 0);
    check("rst_rdata", bus.rdata_to_cpu, 0);
    rst = 1'b0;

    //          name        we    addr          wdata        wait err   rdata         lat cyc sel        dram
    run_access("dram_rd0",  1'b0, 32'h0000_1000, 32'h0,       0,  1'b0, 32'hDEADBEEF, 2,  1,  6'b000000, 1);
    run_access("slot3_wr",  1'b1, 32'hFFFF_F00C, 32'h55,      4,  1'b0, 32'h0,        6,  5,  6'b001000, 0);
    run_access("unmapped",  1'b0, 32'hFFFF_F800, 32'h0,       0,  1'b1, 32'hFFFFFFFF, 1,  0,  6'b000000, 0);
    run_access("wr_forbid", 1'b1, 32'hFFFF_F010, 32'h77,      0,  1'b1, 32'hFFFFFFFF, 1,  0,  6'b000000, 0);
    run_access("rd_forbid", 1'b0, 32'hFFFF_F014, 32'h0,       0,  1'b0, 32'hFFFFFFFF, 1,  0,  6'b000000, 0);
    run_access("slot6_gap", 1'b0, 32'hFFFF_F018, 32'h0,       0,  1'b1, 32'hFFFFFFFF, 1,  0,  6'b000000, 0);
    run_access("timeout",   1'b0, 32'hFFFF_F004, 32'h0,      -1,  1'b1, 32'hFFFFFFFF, 17, 16, 6'b000010, 0);
    run_access("rdy_last",  1'b0, 32'hFFFF_F000, 32'h0,      15,  1'b0, 32'h51000000, 17, 16, 6'b000001, 0);
    run_access("slot4_rd",  1'b0, 32'hFFFF_F010, 32'h0,       0,  1'b0, 32'h51000004, 2,  1,  6'b010000, 0);
    run_access("dram_wr",   1'b1, 32'hFFFF_E000, 32'h1234,    2,  1'b0, 32'h0,        4,  3,  6'b000000, 3);

    spur = 6'b000001;
    run_access("spurious",  1'b0, 32'hFFFF_F008, 32'h0,       3,  1'b0, 32'h51000002, 5,  4,  6'b000100, 0);
    spur = '0;

    // Request pulsed mid-access and held through RESP must not start a new access.
    start_req(1'b0, 32'h0000_2000, 32'h0, 4, e);
    sb_q.push_back('{1'b0, 32'hDEADBEEF, e + 5});
    @(negedge clk);
    bus.req_from_cpu = 1'b0;
    @(negedge clk);
    bus.req_from_cpu  = 1'b1;
    bus.addr_from_cpu = 32'hFFFF_F800;
    @(negedge clk);
    bus.req_from_cpu = 1'b0;
    wait_ack("pulse");
    check("pulse_dram_cycles", dram_run, 5);
    bus.req_from_cpu = 1'b1;
    @(negedge clk);
    bus.req_from_cpu = 1'b0;
    @(negedge clk);
    check("pulse_busy", bus.busy_to_cpu, 0);

    // Reset in cycle E+3 of a never-ready access kills it without an ack.
    start_req(1'b0, 32'hFFFF_F004, 32'h0, -1, e);
    repeat (3) @(negedge clk);
    check("mid_sel_before", bus.sel_to_slv, 6'b000010);
    rst = 1'b1;
    bus.req_from_cpu = 1'b0;
    @(negedge clk);
    check("mid_rst_sel", bus.sel_to_slv, 0);
    check("mid_rst_busy", bus.busy_to_cpu, 0);
    check("mid_rst_ack", bus.ack_to_cpu, 0);
    rst = 1'b0;

    run_access("after_rst", 1'b0, 32'h0000_0040, 32'h0,       1,  1'b0, 32'hDEADBEEF, 3,  2,  6'b000000, 2);

    repeat (5) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    check("bus_stable", stable_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
